vga_scan_gen: RTL and testbench

Raster timing source for the 640x480 @ 60 Hz VGA display. It generates the `row`/`col` scan coordinates consumed by the pixel generators (border, sprites, backgrounds) and accepts their pixel colour back. It delays sync and blanking to match the generators' fixed read latency, then drives the registered `hsync_n`/`vsync_n`/RGB outputs to the DAC pins. The block is the single owner of screen timing.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/sync_delay.sv | 32 +++
 rtl/vga_scan_gen.sv | 97 +++++++++
 tb/tb_vga_scan_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster constants, scan flag bundle and window helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_PIPE_DELAY = 2;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    localparam int RGB_W = 24;

    // Flags carried down the delay line; all-zero means "blank, no sync".
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    // True when a 10-bit counter value lies in the half-open window [lo, hi).
    function automatic logic in_window(input logic [9:0] value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that realigns sync/blank flags with pixel data.
module sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift flags one stage per pixel clock; clear flushes every stage to inactive.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing source: scan coordinates out, delayed sync/blank and colour to the DAC.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [8:0]       row,
    output logic [9:0]       col,
    output logic             line_start,
    output logic             frame_start,
    input  logic [RGB_W-1:0] pix_in,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             video_on,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO     = H_ACTIVE + H_FP;
    localparam int HS_HI     = HS_LO + H_SYNC;
    localparam int VS_LO     = V_ACTIVE + V_FP;
    localparam int VS_HI     = VS_LO + V_SYNC;

    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        line_end;
    logic        frame_end;
    scan_flags_t flags_now;
    scan_flags_t flags_late;

    // Decode end-of-line / end-of-frame from the raw counters.
    always_comb begin
        line_end  = (hcount == 10'(LINE_LEN - 1));
        frame_end = (vcount == 10'(FRAME_LEN - 1));
    end

    // Free-running raster counters; vcount steps only when a line wraps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end) begin
            hcount <= '0;
            vcount <= frame_end ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount <= hcount + 10'd1;
        end
    end

    // Undelayed flags and coordinates for the pixel generators.
    always_comb begin
        flags_now.active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
        flags_now.hs     = in_window(hcount, HS_LO, HS_HI);
        flags_now.vs     = in_window(vcount, VS_LO, VS_HI);
        col              = flags_now.active ? hcount : 10'd0;
        row              = flags_now.active ? vcount[8:0] : 9'd0;
        line_start       = (hcount == 10'd0);
        frame_start      = (hcount == 10'd0) && (vcount == 10'd0);
    end

    sync_delay #(
        .DEPTH (PIPE_DELAY),
        .WIDTH ($bits(scan_flags_t))
    ) u_sync_delay (
        .clk    (clk),
        .resetn (resetn),
        .d      (flags_now),
        .q      (flags_late)
    );

    // Output register: colour is gated by the realigned active flag so porches stay black.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hsync_n  <= 1'b1;
            vsync_n  <= 1'b1;
            video_on <= 1'b0;
            rgb_out  <= '0;
        end else begin
            hsync_n  <= ~flags_late.hs;
            vsync_n  <= ~flags_late.vs;
            video_on <= flags_late.active;
            rgb_out  <= flags_late.active ? pix_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: a default-geometry instance and a short-line instance (full vertical timing).
module tb_vga_scan_gen;

    // Short-line geometry lets a whole 525-line frame run in few cycles.
    localparam int SH_ACTIVE = 16;
    localparam int SH_FP     = 4;
    localparam int SH_SYNC   = 8;
    localparam int SH_BP     = 4;
    localparam int SH_TOTAL  = SH_ACTIVE + SH_FP + SH_SYNC + SH_BP;

    typedef struct packed {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        ls;
        logic        fs;
        logic        hs_n;
        logic        vs_n;
        logic        von;
        logic [23:0] rgb;
    } exp_t;

    localparam exp_t RESET_EXP = '{row: 9'd0, col: 10'd0, ls: 1'b1, fs: 1'b1,
                                   hs_n: 1'b1, vs_n: 1'b1, von: 1'b0, rgb: 24'd0};

    logic        clk;
    logic        resetn;
    logic        pix_ones;
    int          checks;
    int          errors;

    logic [8:0]  row_a, row_b;
    logic [9:0]  col_a, col_b;
    logic        ls_a, ls_b, fs_a, fs_b;
    logic        hs_a, hs_b, vs_a, vs_b, von_a, von_b;
    logic [23:0] pix_a, pix_b, p1_a, p1_b, rgb_a, rgb_b;
    exp_t        obs_a, obs_b;

    vga_scan_gen dut_a (
        .clk(clk), .resetn(resetn), .row(row_a), .col(col_a),
        .line_start(ls_a), .frame_start(fs_a), .pix_in(pix_a),
        .hsync_n(hs_a), .vsync_n(vs_a), .video_on(von_a), .rgb_out(rgb_a)
    );

    vga_scan_gen #(
        .H_ACTIVE(SH_ACTIVE), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP)
    ) dut_b (
        .clk(clk), .resetn(resetn), .row(row_b), .col(col_b),
        .line_start(ls_b), .frame_start(fs_b), .pix_in(pix_b),
        .hsync_n(hs_b), .vsync_n(vs_b), .video_on(von_b), .rgb_out(rgb_b)
    );

    assign obs_a = {row_a, col_a, ls_a, fs_a, hs_a, vs_a, von_a, rgb_a};
    assign obs_b = {row_b, col_b, ls_b, fs_b, hs_b, vs_b, von_b, rgb_b};

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Pixel generator model: returns the colour for a coordinate two cycles after it is issued.
    always @(posedge clk) begin
        p1_a  <= {row_a[7:0], col_a[7:0], 8'hA5};
        p1_b  <= {row_b[7:0], col_b[7:0], 8'hA5};
        pix_a <= pix_ones ? 24'hFFFFFF : p1_a;
        pix_b <= pix_ones ? 24'hFFFFFF : p1_b;
    end

    // Expected outputs at cycle k after reset release, from the raster definition alone.
    function automatic exp_t model(input int k, input int ha, input int hfp, input int hsy,
                                   input int hbp, input bit ones);
        exp_t e;
        int   ht, h, v, d, hd, vd;
        ht     = ha + hfp + hsy + hbp;
        h      = k % ht;
        v      = (k / ht) % 525;
        e.row  = (h < ha && v < 480) ? 9'(v) : 9'd0;
        e.col  = (h < ha && v < 480) ? 10'(h) : 10'd0;
        e.ls   = (h == 0);
        e.fs   = (h == 0) && (v == 0);
        e.hs_n = 1'b1;
        e.vs_n = 1'b1;
        e.von  = 1'b0;
        e.rgb  = 24'd0;
        if (k >= 3) begin
            d      = k - 3;
            hd     = d % ht;
            vd     = (d / ht) % 525;
            e.von  = (hd < ha) && (vd < 480);
            e.hs_n = !((hd >= ha + hfp) && (hd < ha + hfp + hsy));
            e.vs_n = !((vd >= 490) && (vd < 492));
            if (e.von) e.rgb = ones ? 24'hFFFFFF : {8'(vd), 8'(hd), 8'hA5};
        end
        return e;
    endfunction

    task automatic hold_reset(input int n);
        @(negedge clk);
        resetn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (10) @(negedge clk);
        checks += 10;
        if (hs_a !== 1'b1)    begin errors++; $display("[TB] FAIL reset.hsync_n got=%b exp=1", hs_a); end
        if (vs_a !== 1'b1)    begin errors++; $display("[TB] FAIL reset.vsync_n got=%b exp=1", vs_a); end
        if (rgb_a !== 24'd0)  begin errors++; $display("[TB] FAIL reset.rgb got=%h exp=0", rgb_a); end
        if (row_a !== 9'd0)   begin errors++; $display("[TB] FAIL reset.row got=%0d exp=0", row_a); end
        if (col_a !== 10'd0)  begin errors++; $display("[TB] FAIL reset.col got=%0d exp=0", col_a); end
        if (fs_a !== 1'b1)    begin errors++; $display("[TB] FAIL reset.frame_start got=%b exp=1", fs_a); end
        if (ls_a !== 1'b1)    begin errors++; $display("[TB] FAIL reset.line_start got=%b exp=1", ls_a); end
        if (von_a !== 1'b0)   begin errors++; $display("[TB] FAIL reset.video_on got=%b exp=0", von_a); end
        if (obs_b !== RESET_EXP) begin errors++; $display("[TB] FAIL reset.short got=%h exp=%h", obs_b, RESET_EXP); end
        if (vs_b !== 1'b1)    begin errors++; $display("[TB] FAIL reset.short_vsync_n got=%b exp=1", vs_b); end
    endtask

    task automatic test_first_line(input string tag);
        int fall_k, rise_k, ls_count, max_col;
        exp_t ea, eb;
        fall_k = -1; rise_k = -1; ls_count = 0; max_col = 0;
        hold_reset(10);
        resetn = 1'b1;
        for (int k = 0; k <= 800; k++) begin
            if (k > 0) @(negedge clk);
            ea = model(k, 640, 16, 96, 48, 1'b0);
            eb = model(k, SH_ACTIVE, SH_FP, SH_SYNC, SH_BP, 1'b0);
            checks += 2;
            if (obs_a !== ea) begin errors++; $display("[TB] FAIL %s.A k=%0d got=%h exp=%h", tag, k, obs_a, ea); end
            if (obs_b !== eb) begin errors++; $display("[TB] FAIL %s.B k=%0d got=%h exp=%h", tag, k, obs_b, eb); end
            if (fall_k < 0 && hs_a === 1'b0) fall_k = k;
            if (fall_k >= 0 && rise_k < 0 && hs_a === 1'b1) rise_k = k;
            if (ls_a === 1'b1) ls_count++;
            if (int'(col_a) > max_col) max_col = int'(col_a);
        end
        checks += 4;
        if (fall_k != 659)  begin errors++; $display("[TB] FAIL %s.hsync_fall got=%0d exp=659", tag, fall_k); end
        if (rise_k != 755)  begin errors++; $display("[TB] FAIL %s.hsync_rise got=%0d exp=755", tag, rise_k); end
        if (ls_count != 2)  begin errors++; $display("[TB] FAIL %s.line_start_pulses got=%0d exp=2", tag, ls_count); end
        if (max_col != 639) begin errors++; $display("[TB] FAIL %s.max_col got=%0d exp=639", tag, max_col); end
    endtask

    task automatic test_alignment();
        exp_t ea, eb;
        hold_reset(10);
        resetn = 1'b1;
        for (int k = 0; k <= 2400; k++) begin
            if (k > 0) @(negedge clk);
            ea = model(k, 640, 16, 96, 48, 1'b0);
            eb = model(k, SH_ACTIVE, SH_FP, SH_SYNC, SH_BP, 1'b0);
            checks += 2;
            if (obs_a !== ea) begin errors++; $display("[TB] FAIL align.A k=%0d got=%h exp=%h", k, obs_a, ea); end
            if (obs_b !== eb) begin errors++; $display("[TB] FAIL align.B k=%0d got=%h exp=%h", k, obs_b, eb); end
        end
    endtask

    task automatic test_frame();
        int vs_first, vs_low, fs_count, max_row;
        exp_t ea, eb;
        vs_first = -1; vs_low = 0; fs_count = 0; max_row = 0;
        hold_reset(10);
        resetn = 1'b1;
        for (int k = 0; k <= 525 * SH_TOTAL; k++) begin
            if (k > 0) @(negedge clk);
            ea = model(k, 640, 16, 96, 48, 1'b0);
            eb = model(k, SH_ACTIVE, SH_FP, SH_SYNC, SH_BP, 1'b0);
            checks += 2;
            if (obs_a !== ea) begin errors++; $display("[TB] FAIL frame.A k=%0d got=%h exp=%h", k, obs_a, ea); end
            if (obs_b !== eb) begin errors++; $display("[TB] FAIL frame.B k=%0d got=%h exp=%h", k, obs_b, eb); end
            if (vs_b === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (fs_b === 1'b1) fs_count++;
            if (int'(row_b) > max_row) max_row = int'(row_b);
        end
        checks += 4;
        if (vs_first != 490 * SH_TOTAL + 3) begin errors++; $display("[TB] FAIL frame.vsync_fall got=%0d exp=%0d", vs_first, 490 * SH_TOTAL + 3); end
        if (vs_low != 2 * SH_TOTAL) begin errors++; $display("[TB] FAIL frame.vsync_width got=%0d exp=%0d", vs_low, 2 * SH_TOTAL); end
        if (fs_count != 2)  begin errors++; $display("[TB] FAIL frame.frame_start_pulses got=%0d exp=2", fs_count); end
        if (max_row != 479) begin errors++; $display("[TB] FAIL frame.max_row got=%0d exp=479", max_row); end
    endtask

    task automatic test_blanking();
        exp_t ea, eb;
        pix_ones = 1'b1;
        hold_reset(10);
        resetn = 1'b1;
        for (int k = 0; k <= 1700; k++) begin
            if (k > 0) @(negedge clk);
            ea = model(k, 640, 16, 96, 48, 1'b1);
            eb = model(k, SH_ACTIVE, SH_FP, SH_SYNC, SH_BP, 1'b1);
            checks += 2;
            if (obs_a !== ea) begin errors++; $display("[TB] FAIL blank.A k=%0d got=%h exp=%h", k, obs_a, ea); end
            if (obs_b !== eb) begin errors++; $display("[TB] FAIL blank.B k=%0d got=%h exp=%h", k, obs_b, eb); end
        end
        pix_ones = 1'b0;
    endtask

    task automatic test_mid_frame_reset(input int stop_k, input string tag);
        exp_t ea, eb;
        hold_reset(10);
        resetn = 1'b1;
        for (int k = 0; k <= stop_k; k++) begin
            if (k > 0) @(negedge clk);
            ea = model(k, 640, 16, 96, 48, 1'b0);
            eb = model(k, SH_ACTIVE, SH_FP, SH_SYNC, SH_BP, 1'b0);
            checks += 2;
            if (obs_a !== ea) begin errors++; $display("[TB] FAIL %s.run_A k=%0d got=%h exp=%h", tag, k, obs_a, ea); end
            if (obs_b !== eb) begin errors++; $display("[TB] FAIL %s.run_B k=%0d got=%h exp=%h", tag, k, obs_b, eb); end
        end
        resetn = 1'b0;
        @(negedge clk);
        checks += 2;
        if (obs_a !== RESET_EXP) begin errors++; $display("[TB] FAIL %s.edge_A got=%h exp=%h", tag, obs_a, RESET_EXP); end
        if (obs_b !== RESET_EXP) begin errors++; $display("[TB] FAIL %s.edge_B got=%h exp=%h", tag, obs_b, RESET_EXP); end
        test_first_line({tag, "_line"});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        pix_ones = 1'b0;
        $display("[TB] starting vga_scan_gen bench");
        test_reset();
        test_first_line("first_line");
        test_alignment();
        test_frame();
        test_blanking();
        test_mid_frame_reset(700, "mid_reset_a");
        test_mid_frame_reset(200 * SH_TOTAL + 24, "mid_reset_b");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
